// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//
// Contents:
//   UART_DATA_BITS   - payload bits per frame (8)
//   uart_state_e     - transmitter FSM state encoding
//   uart_div()       - rounded clocks-per-bit divider
//
// Compile-time option: UART_TX_PARITY_EN adds the PARITY state (8E1 frames).
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;
`endif

  // Clocks per bit, rounded to the nearest integer. Done in 64 bits so a
  // large clock frequency cannot overflow the intermediate sum.
  function automatic int uart_div(input int clk_hz, input int baud);
    longint sum;
    sum = longint'(clk_hz) + (longint'(baud) / 2);
    return int'(sum / longint'(baud));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, reusable by both TX and RX paths.
//
// Parameters:
//   WIDTH - entry width in bits
//   DEPTH - number of entries; power of two, at least 2
//
// Ports:
//   clk      in  1          clock
//   rst      in  1          synchronous active-high reset (empties the FIFO)
//   wr_en    in  1          push request; ignored while full
//   wr_data  in  WIDTH      data to push
//   rd_en    in  1          pop request; ignored while empty
//   rd_data  out WIDTH      head entry (valid while not empty)
//   count    out log2(D)+1  number of stored entries
//   full     out 1          count == DEPTH
//   empty    out 1          count == 0
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Pointers wrap by natural overflow, which only works for power-of-two
  // depths.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // A simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until the count says it is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: queued byte-to-serial UART transmitter.
//
// Accepts one-cycle byte strobes from upstream into a small FIFO and sends
// each byte LSB first as 8N1 (or 8E1 with UART_TX_PARITY_EN defined).
// Queued bytes are sent back-to-back with no idle gap between frames.
//
// Parameters:
//   CLK_HZ     - system clock frequency in Hz
//   BAUD       - line rate
//   FIFO_DEPTH - queue entries (power of two, at least 2)
//
// Ports:
//   clk      in  1  system clock
//   rst      in  1  synchronous active-high reset
//   tx_en    in  1  write strobe
//   tx_data  in  8  byte to queue, sampled when tx_en is high
//   tx_busy  out 1  registered queue-full flag
//   tx       out 1  registered serial line, idle high
//
// Compile-time option: UART_TX_PARITY_EN adds an even parity bit.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);

  localparam int DIV   = uart_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_queue: CLK_HZ/BAUD gives fewer than 2 clocks per bit");
  end

  uart_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [2:0]                  bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic                        tx_q, tx_d;
  logic                        tx_busy_q, tx_busy_d;
`ifdef UART_TX_PARITY_EN
  logic                        parity_q, parity_d;
`endif

  logic                        pop;
  logic                        bit_end;
  logic [UART_DATA_BITS-1:0]   fifo_head;
  logic [FCW-1:0]              fifo_count;
  logic                        fifo_empty;
  logic                        unused_fifo_full;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_en),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (unused_fifo_full),
    .empty   (fifo_empty)
  );

  assign bit_end = (cnt_q == CNT_W'(DIV - 1));
  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

  // Next-state logic. The baud counter runs 0..DIV-1 in every non-idle
  // state; the state advances on its last count. STOP pops the next byte
  // directly so queued frames follow each other without an idle bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_head;
`endif
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_head;
`endif
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line value is decoded from the current state and registered, so tx
  // trails the state by one clock and every bit still lasts DIV cycles.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  // Busy follows the registered occupancy, one edge behind the fill/pop.
  always_comb begin
    tx_busy_d = (fifo_count == FCW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      tx_busy_q <= tx_busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: self-checking bench for uart_tx_queue.
// A frame-level reference model predicts tx and tx_busy every cycle;
// literal expectations pin the model. Honours UART_TX_PARITY_EN.
module tb_uart_tx_queue;

  localparam int CLK_HZ = 8;
  localparam int BAUD   = 1;
  localparam int DEPTH  = 4;
  localparam int DIV    = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS  = 11;
`else
  localparam int NBITS  = 10;
`endif
  localparam int FL     = NBITS * DIV;

  logic       clk = 1'b0;
  logic       rst, tx_en;
  logic [7:0] tx_data;
  logic       tx, tx_busy;
  logic       rst2, tx_en2;
  logic [7:0] tx_data2;
  logic       tx2, tx_busy2;

  always #5 clk = ~clk;

  uart_tx_queue #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx      (tx)
  );

  uart_tx_queue dut2 (
    .clk     (clk),
    .rst     (rst2),
    .tx_en   (tx_en2),
    .tx_data (tx_data2),
    .tx_busy (tx_busy2),
    .tx      (tx2)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Full frame as a bit list, index 0 first on the line.
  function automatic logic [10:0] frameBits(input logic [7:0] d);
    logic [10:0] b;
    b      = '1;
    b[0]   = 1'b0;
    b[8:1] = d;
`ifdef UART_TX_PARITY_EN
    b[9]   = ^d;
`endif
    return b;
  endfunction

  // Reference model: queue of bytes plus the frame in flight.
  logic [7:0]  mq[$];
  bit          f_active = 0;
  longint      f_start  = 0;
  logic [10:0] f_bits   = '1;
  longint      edge_n   = 0;
  logic        exp_tx   = 1'b1;
  logic        exp_busy = 1'b0;
  bit          mdl_ready = 0;

  always @(posedge clk) begin : model
    int sz;
    edge_n++;
    if (rst) begin
      mq.delete();
      f_active  = 0;
      exp_tx    = 1'b1;
      exp_busy  = 1'b0;
      mdl_ready = 1;
    end else begin
      sz       = mq.size();
      exp_busy = (sz == DEPTH);
      if (f_active && edge_n > f_start && edge_n <= f_start + FL)
        exp_tx = f_bits[int'((edge_n - f_start - 1) / DIV)];
      else
        exp_tx = 1'b1;
      if (f_active && edge_n == f_start + FL) f_active = 0;
      if (!f_active && sz > 0) begin
        f_bits   = frameBits(mq.pop_front());
        f_start  = edge_n;
        f_active = 1;
      end
      if (tx_en && sz < DEPTH) mq.push_back(tx_data);
    end
  end

  always @(negedge clk) begin
    if (mdl_ready) begin
      checkOutput("tx_vs_model", 32'(tx), 32'(exp_tx));
      checkOutput("busy_vs_model", 32'(tx_busy), 32'(exp_busy));
    end
  end

  // Drive one cycle of inputs; they are sampled at the following posedge.
  task automatic applyStimulus(input logic en, input logic [7:0] d, input logic r);
    @(negedge clk);
    tx_en   = en;
    tx_data = d;
    rst     = r;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int trans;
    logic prev;
    logic [10:0] lit;
    int waited, width, rate;
    bit proto, last_en;
    logic en;

    rst = 1'b1; tx_en = 1'b0; tx_data = '0;
    rst2 = 1'b1; tx_en2 = 1'b0; tx_data2 = '0;

    // Reset and quiet line
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(tx_busy), 32'd0);
    trans = 0; prev = tx;
    repeat (100) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (tx !== prev) trans++;
      prev = tx;
    end
    checkOutput("idle_transitions", 32'(trans), 32'd0);

    // Single byte 0x41 with literal bit pattern
`ifdef UART_TX_PARITY_EN
    lit = 11'b10010000010;
`else
    lit = 11'b01010000010;
`endif
    applyStimulus(1'b1, 8'h41, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("latency_E0", 32'(tx), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("latency_E1", 32'(tx), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("latency_E2", 32'(tx), 32'd0);
    for (int k = 0; k < NBITS; k++) begin
      repeat (4) applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput($sformatf("bit41_%0d", k), 32'(tx), 32'(lit[k]));
      repeat (4) applyStimulus(1'b0, 8'h00, 1'b0);
    end
    checkOutput("idle_after_frame", 32'(tx), 32'd1);

    // Burst of six bytes into a four-deep queue
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0);
      if (i == 5) checkOutput("busy_before_full_edge", 32'(tx_busy), 32'd0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("busy_after_fill", 32'(tx_busy), 32'd1);
    repeat (5 * FL + 20) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("idle_after_burst", 32'(tx), 32'd1);

    // Reset mid-frame, with a write strobe during reset
    applyStimulus(1'b1, 8'hA5, 1'b0);
    repeat (30) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midreset_tx", 32'(tx), 32'd1);
    checkOutput("midreset_busy", 32'(tx_busy), 32'd0);
    trans = 0; prev = tx;
    repeat (100) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (tx !== prev) trans++;
      prev = tx;
    end
    checkOutput("midreset_no_frame", 32'(trans), 32'd0);

`ifdef UART_TX_PARITY_EN
    // Parity bit for 0x43 is 1
    applyStimulus(1'b1, 8'h43, 1'b0);
    repeat (3 + 76) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("parity_43", 32'(tx), 32'd1);
    repeat (20) applyStimulus(1'b0, 8'h00, 1'b0);
`endif

    // Randomized traffic, alternating protocol-following and flooding
    last_en = 0;
    for (int blk = 0; blk < 6; blk++) begin
      rate  = $urandom_range(5, 90);
      proto = blk[0];
      repeat (400) begin
        en = ($urandom_range(0, 99) < rate);
        if (proto) en = en && !tx_busy && !last_en;
        last_en = en;
        applyStimulus(en, 8'($urandom), ($urandom_range(0, 299) == 0));
      end
    end
    repeat (5 * FL + 20) applyStimulus(1'b0, 8'h00, 1'b0);

    // Default parameters: start bit must last 104 clocks
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst2 = 1'b0; tx_en2 = 1'b1; tx_data2 = 8'h01;
    @(negedge clk);
    tx_en2 = 1'b0;
    waited = 0;
    while (tx2 !== 1'b0 && waited < 10) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      waited++;
    end
    checkOutput("div104_start_seen", 32'(tx2), 32'd0);
    width = 0;
    while (tx2 === 1'b0 && width < 300) begin
      width++;
      applyStimulus(1'b0, 8'h00, 1'b0);
    end
    checkOutput("div104_start_width", 32'(width), 32'd104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte-to-serial UART transmitter with a small input queue. It sits directly downstream of the puzzle logic: it consumes the one-cycle `output_en`/`output_data` byte strobes and drives back `output_busy`. It serializes each byte as 8N1, or 8E1 when parity is compiled in, onto the board TX pin.

## Interface

Clock is `clk`. Reset is `rst`: synchronous, active-high, one clock domain.

Parameters:
- `CLK_HZ`, default 12000000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `FIFO_DEPTH`, default 4: queue entries; power of two, ≥2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `tx_en` in 1: write strobe; connects to the upstream `output_en`.
- `tx_data` in 8: byte to queue; sampled when `tx_en` is high.
- `tx_busy` out 1: queue full; connects to the upstream `output_busy`.
- `tx` out 1: serial line; idle high.

## Operation

- Bit period:
  - `DIV = (CLK_HZ + BAUD/2) / BAUD`, computed at elaboration; rounds to nearest.
  - Counter width is `$clog2(DIV)`.
  - Elaboration error if `DIV < 2`.
- Queue:
  - A write is accepted on an edge where `tx_en=1` and the registered count is below `FIFO_DEPTH`.
  - A write while full is silently dropped.
  - Push and pop on the same edge leave the count unchanged.
- `tx_busy` is registered and equals (count == `FIFO_DEPTH`).
- FSM states are IDLE, START, DATA, PARITY (only when enabled), STOP.
  - IDLE: `tx=1`. When count>0, pop the head into the shift register and go to START.
  - START: `tx=0` for DIV cycles, then go to DATA.
  - DATA: shift out 8 bits, LSB first, DIV cycles each. A 3-bit index tracks the bit. After bit 7, go to PARITY or STOP.
  - PARITY: `tx` = XOR of the byte (even parity) for DIV cycles.
  - STOP: `tx=1` for DIV cycles. At the end:
    - count>0: pop and go straight to START, so queued frames run back-to-back with no idle gap.
    - otherwise: go to IDLE.
- The `tx` output is registered; no combinational path from any input to `tx` or `tx_busy`.

## Timing

- Reset values: `tx=1`, `tx_busy=0`, queue empty, FSM in IDLE, bit counter 0.
- Latency: a byte accepted into an empty, idle block at edge E drives `tx` low from edge E+2.
- Frame length is 10·DIV cycles (11·DIV with parity). Every bit lasts exactly DIV cycles.
- `tx_busy` rises on the edge after the accepting write that fills the queue. It falls on the edge after the pop that frees a slot.
- Upstream protocol (strobe one cycle, then wait for `tx_busy` low before the next strobe) never loses bytes.
- Reset asserted mid-frame:
  - `tx` returns high on that edge.
  - All queued bytes and the frame in flight are discarded.
  - `tx_en` asserted together with `rst` is ignored.

## Configuration

- `UART_TX_PARITY_EN` defined: PARITY state present; 8E1 frames, 11 bit periods.
- `UART_TX_PARITY_EN` not defined: no PARITY state or parity logic; 8N1 frames, 10 bit periods.

## Structure

- Shared package `uart_pkg`:
  - FSM state enum.
  - `uart_div(clk_hz, baud)` function for the rounded divider.
  - Constant `UART_DATA_BITS = 8`.
- One sub-module, `sync_fifo`. It is parameterized on width and depth and provides count and full/empty. It is reusable by a future RX stage.
- FSM, baud counter and shifter live in `uart_tx_queue`.

## Test plan

Tests 1–5 use `CLK_HZ=8`, `BAUD=1` (DIV=8), `FIFO_DEPTH=4`.

1. Reset: hold `rst` 3 cycles → `tx=1`, `tx_busy=0`; no `tx` transition for 100 cycles.
2. Single byte: write 0x41 at edge E → `tx` low from E+2. Bit sequence is 0,1,0,0,0,0,0,1,0,1, each 8 cycles. Idle high after 80 cycles.
3. Burst: write 0x10..0x15 on 6 consecutive edges → `tx_busy` high after the 5th accept and 0x15 dropped. Frames for 0x10..0x14 run gap-free over 400 cycles.
4. Reset mid-frame: write 0xA5, assert `rst` 30 cycles in → `tx=1` the next cycle, `tx_busy=0`, no further frame.
5. With `UART_TX_PARITY_EN`: 0x41 gives parity bit 0 and 0x43 gives parity bit 1. Each frame is 88 cycles.
6. With `CLK_HZ=12000000`, `BAUD=115200` → DIV=104. Measure the start-bit width as exactly 104 cycles.
